// File: rtl/sensor_frame_rx_if.sv
// Output stream of the frame checker: one beat per frame with the recovered
// pattern and the per-frame error flags.
interface sensor_frame_rx_if #(
   parameter int PATTERN_WIDTH = 32
);
   logic [PATTERN_WIDTH-1:0] OUT_TDATA;
   logic [3:0]               OUT_TUSER;
   logic                     OUT_TVALID;
   logic                     OUT_TREADY;

   modport master (output OUT_TDATA, OUT_TUSER, OUT_TVALID, input OUT_TREADY);
   modport slave  (input OUT_TDATA, OUT_TUSER, OUT_TVALID, output OUT_TREADY);
endinterface

// File: rtl/sensor_frame_rx.sv
// LVDS frame checker: locks on idle/header, checks header/data/footer and
// emits one stream beat per frame with the recovered pattern and error flags.
module sensor_frame_rx #(
   parameter int PATTERN_WIDTH = 32,
   parameter int LVDS_WIDTH    = 512
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [LVDS_WIDTH-1:0] lvds,
   input  logic [31:0]           cycles_per_frame,
   input  logic [7:0]            idle_1,
   input  logic [31:0]           frame_header,
   sensor_frame_rx_if.master     out_if,
   output logic                  in_frame,
   output logic                  cfg_err,
   output logic [31:0]           frame_count,
   output logic [31:0]           error_count,
   output logic [31:0]           drop_count
);
   localparam int NB = LVDS_WIDTH / 8;
   localparam int PB = PATTERN_WIDTH / 8;
   localparam int PW = (PB > 1) ? $clog2(PB) : 1;

   typedef enum logic [1:0] {HUNT, HEADER, DATA, FOOTER} state_t;
   state_t state, state_nxt;

   logic [31:0]          cyc, cpf;
   logic                 start_ok;
   logic                 hdr_err, data_err, ftr_err;
   logic [PB-1:0]        cap;
   logic [PB-1:0][7:0]   pat;

   logic                 lock, last_ftr, uniform, hdr_bad, ftr_bad;
   logic [PW-1:0]        pidx;
   logic [LVDS_WIDTH-1:0] hdr_exp, ramp;
   logic [PATTERN_WIDTH-1:0] beat_data;
   logic [3:0]           beat_user;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   for (genvar j = 0; j < NB; j++) begin : g_ramp
      assign ramp[8*j +: 8] = 8'(j % 256);
   end

   assign uniform  = (lvds == {NB{lvds[7:0]}});
   assign lock     = (state == HUNT) && (lvds == {NB{frame_header[7:0]}}) && start_ok && !cfg_err;
   assign last_ftr = (state == FOOTER) && (cyc == cpf - 32'd1);
   assign hdr_bad  = (state == HEADER) && (lvds != hdr_exp);
   assign ftr_bad  = (state == FOOTER) && (lvds != '0);
   // slot k = cyc[4:2]; taking its low bits is k mod PATTERN_BYTES
   assign pidx     = (PB > 1) ? cyc[2 +: PW] : '0;

   always_comb begin
      hdr_exp = '0;
      case (cyc[3:0])
         4'd1:    hdr_exp = {NB{frame_header[15:8]}};
         4'd2:    hdr_exp = {NB{frame_header[23:16]}};
         4'd3:    hdr_exp = {NB{frame_header[31:24]}};
         4'd11:   hdr_exp = ramp;
         default: hdr_exp = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= HUNT;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HUNT:    if (lock)                      state_nxt = HEADER;
         HEADER:  if (cyc == 32'd15)             state_nxt = DATA;
         DATA:    if (cyc == cpf - 32'd5)        state_nxt = FOOTER;
         FOOTER:  if (cyc == cpf - 32'd1)        state_nxt = HUNT;
         default:                                state_nxt = HUNT;
      endcase
   end

   always_comb begin
      in_frame = (state != HUNT);
   end

   // Lock cycle is header cyc 0, so the counter resumes at 1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cyc      <= '0;
         cpf      <= '0;
         start_ok <= 1'b0;
         cfg_err  <= 1'b0;
         hdr_err  <= 1'b0;
         data_err <= 1'b0;
         ftr_err  <= 1'b0;
         cap      <= '0;
         pat      <= '0;
      end else begin
         cfg_err  <= (cycles_per_frame < 32'd21);
         start_ok <= (lvds == {NB{idle_1}}) || last_ftr;
         if (lock) begin
            cyc      <= 32'd1;
            cpf      <= cycles_per_frame;
            hdr_err  <= 1'b0;
            data_err <= 1'b0;
            ftr_err  <= 1'b0;
            cap      <= '0;
            pat      <= '0;
         end else if (state != HUNT) begin
            cyc <= cyc + 32'd1;
         end
         if (hdr_bad) hdr_err <= 1'b1;
         if (ftr_bad) ftr_err <= 1'b1;
         if (state == DATA) begin
            if (!uniform)                 data_err <= 1'b1;
            else if (!cap[pidx]) begin
               cap[pidx] <= 1'b1;
               pat[pidx] <= lvds[7:0];
            end else if (pat[pidx] != lvds[7:0]) data_err <= 1'b1;
         end
      end
   end

   // Last footer word is folded in here since its flag is not yet registered.
   always_comb begin
      beat_data = '0;
      for (int i = 0; i < PB; i++)
         beat_data[8*(PB-1-i) +: 8] = cap[i] ? pat[i] : 8'h00;
      beat_user = {~&cap, ftr_err | ftr_bad, data_err, hdr_err};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_if.OUT_TVALID <= 1'b0;
         out_if.OUT_TDATA  <= '0;
         out_if.OUT_TUSER  <= '0;
         frame_count       <= '0;
         error_count       <= '0;
         drop_count        <= '0;
      end else if (last_ftr) begin
         frame_count <= sat_inc(frame_count);
         if (|beat_user) error_count <= sat_inc(error_count);
         if (!out_if.OUT_TVALID || out_if.OUT_TREADY) begin
            out_if.OUT_TVALID <= 1'b1;
            out_if.OUT_TDATA  <= beat_data;
            out_if.OUT_TUSER  <= beat_user;
         end else begin
            drop_count <= sat_inc(drop_count);
         end
      end else if (out_if.OUT_TREADY) begin
         out_if.OUT_TVALID <= 1'b0;
      end
   end
endmodule
